// File: rtl/axi_lite_sram_pkg.sv
`default_nettype none
// ============================================================================
// axi_lite_sram_pkg : shared response codes and FSM/grant encodings
// Revision 1.0
// ============================================================================
package axi_lite_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_hold_buf.sv
`default_nettype none
// ============================================================================
// axi_lite_hold_buf : one-entry valid/ready holding register
// Revision 1.0
// ============================================================================
module axi_lite_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  input  logic             pop
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      out_data <= '0;
    end else if (in_valid && !full) begin
      full     <= 1'b1;
      out_data <= in_data;
    end else if (pop) begin
      full     <= 1'b0;
    end
  end

  assign in_ready = !full;

endmodule
`default_nettype wire

// File: rtl/axi_lite_sram_bridge.sv
`default_nettype none
// ============================================================================
// axi_lite_sram_bridge : AXI5-Lite slave onto a single-port synchronous SRAM
// Revision 1.0
// ============================================================================
module axi_lite_sram_bridge
  import axi_lite_sram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 1,
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_RD_LAT     = 1
) (
  input  logic                       AXI_CLK,
  input  logic                       RST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [ID_WIDTH-1:0]        AWID,
  input  logic [ADDR_WIDTH-1:0]      AWADDR,
  input  logic [2:0]                 AWPROT,
  input  logic                       WVALID,
  output logic                       WREADY,
  input  logic [DATA_WIDTH-1:0]      WDATA,
  input  logic [DATA_WIDTH/8-1:0]    WSTRB,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [ID_WIDTH-1:0]        BID,
  output logic [1:0]                 BRESP,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  input  logic [ID_WIDTH-1:0]        ARID,
  input  logic [ADDR_WIDTH-1:0]      ARADDR,
  input  logic [2:0]                 ARPROT,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [ID_WIDTH-1:0]        RID,
  output logic [DATA_WIDTH-1:0]      RDATA,
  output logic [1:0]                 RRESP,
  output logic                       SRAM_CS,
  output logic                       SRAM_WE,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0]      SRAM_DATA_W,
  output logic [DATA_WIDTH/8-1:0]    SRAM_BE,
  input  logic [DATA_WIDTH-1:0]      SRAM_DATA_R
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int AW_BITS    = ID_WIDTH + ADDR_WIDTH;
  localparam int W_BITS     = DATA_WIDTH + STRB_WIDTH;
  localparam int CNT_WIDTH  = 3;

  logic                       aw_full, w_full, ar_full;
  logic                       aw_pop, w_pop, ar_pop;
  logic [AW_BITS-1:0]         aw_q, ar_q;
  logic [W_BITS-1:0]          w_q;
  logic [ID_WIDTH-1:0]        aw_id, ar_id;
  logic [ADDR_WIDTH-1:0]      aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]      w_data;
  logic [STRB_WIDTH-1:0]      w_strb;
  logic                       aw_ok, ar_ok;
  logic                       wr_cand, rd_cand, grant_wr, grant_rd, rd_done;
  logic [CNT_WIDTH-1:0]       cnt;
  logic [ID_WIDTH-1:0]        rd_id;
  logic                       rd_ok;
  state_e                     state, state_next;
  grant_e                     last_grant;
  logic                       unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  axi_lite_hold_buf #(.WIDTH(AW_BITS)) u_aw_buf (
    .clk(AXI_CLK), .rst(RST), .in_valid(AWVALID), .in_ready(AWREADY),
    .in_data({AWID, AWADDR}), .full(aw_full), .out_data(aw_q), .pop(aw_pop)
  );

  axi_lite_hold_buf #(.WIDTH(W_BITS)) u_w_buf (
    .clk(AXI_CLK), .rst(RST), .in_valid(WVALID), .in_ready(WREADY),
    .in_data({WDATA, WSTRB}), .full(w_full), .out_data(w_q), .pop(w_pop)
  );

  axi_lite_hold_buf #(.WIDTH(AW_BITS)) u_ar_buf (
    .clk(AXI_CLK), .rst(RST), .in_valid(ARVALID), .in_ready(ARREADY),
    .in_data({ARID, ARADDR}), .full(ar_full), .out_data(ar_q), .pop(ar_pop)
  );

  assign aw_id   = aw_q[AW_BITS-1 -: ID_WIDTH];
  assign aw_addr = aw_q[ADDR_WIDTH-1:0];
  assign ar_id   = ar_q[AW_BITS-1 -: ID_WIDTH];
  assign ar_addr = ar_q[ADDR_WIDTH-1:0];
  assign w_data  = w_q[W_BITS-1 -: DATA_WIDTH];
  assign w_strb  = w_q[STRB_WIDTH-1:0];

  // Anything above the SRAM word index decodes as a hole.
  assign aw_ok = (aw_addr >> (LSB + SRAM_ADDR_WIDTH)) == '0;
  assign ar_ok = (ar_addr >> (LSB + SRAM_ADDR_WIDTH)) == '0;

  // A response slot counts as free in the cycle its handshake completes.
  assign wr_cand = aw_full && w_full && (!BVALID || BREADY);
  assign rd_cand = ar_full && (!RVALID || RREADY);
  assign rd_done = (state == RD_WAIT) && (cnt == CNT_WIDTH'(SRAM_RD_LAT - 1));

  always_ff @(posedge AXI_CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_cand && (!rd_cand || last_grant == GNT_RD)) begin
          grant_wr   = 1'b1;
          state_next = WRITE;
        end else if (rd_cand) begin
          grant_rd   = 1'b1;
          state_next = RD_WAIT;
        end
      end
      WRITE:   state_next = IDLE;
      RD_WAIT: if (rd_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The SRAM strobe is issued in the grant cycle itself.
  always_comb begin
    aw_pop      = grant_wr;
    w_pop       = grant_wr;
    ar_pop      = grant_rd;
    SRAM_CS     = 1'b0;
    SRAM_WE     = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_DATA_W = '0;
    SRAM_BE     = '0;
    if (grant_wr && aw_ok) begin
      SRAM_CS     = 1'b1;
      SRAM_WE     = 1'b1;
      SRAM_ADDR   = aw_addr[LSB +: SRAM_ADDR_WIDTH];
      SRAM_DATA_W = w_data;
      SRAM_BE     = w_strb;
    end else if (grant_rd && ar_ok) begin
      SRAM_CS     = 1'b1;
      SRAM_ADDR   = ar_addr[LSB +: SRAM_ADDR_WIDTH];
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RST) begin
      last_grant <= GNT_WR;
      cnt        <= '0;
      rd_id      <= '0;
      rd_ok      <= 1'b0;
    end else begin
      if (grant_wr)      last_grant <= GNT_WR;
      else if (grant_rd) last_grant <= GNT_RD;
      if (state == RD_WAIT) cnt <= cnt + 1'b1;
      else                  cnt <= '0;
      if (grant_rd) begin
        rd_id <= ar_id;
        rd_ok <= ar_ok;
      end
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RST) begin
      BVALID <= 1'b0;
      BID    <= '0;
      BRESP  <= RESP_OKAY;
    end else if (grant_wr) begin
      BVALID <= 1'b1;
      BID    <= aw_id;
      BRESP  <= aw_ok ? RESP_OKAY : RESP_DECERR;
    end else if (BREADY) begin
      BVALID <= 1'b0;
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RST) begin
      RVALID <= 1'b0;
      RID    <= '0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (rd_done) begin
      RVALID <= 1'b1;
      RID    <= rd_id;
      RDATA  <= rd_ok ? SRAM_DATA_R : '0;
      RRESP  <= rd_ok ? RESP_OKAY : RESP_DECERR;
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

endmodule
`default_nettype wire
